// File: rtl/stm_mod_mixer.sv
// ============================================================================
// stm_mod_mixer: scales stm intensity beats by a per-frame modulation sample.
// Revision: 1.0
// ============================================================================
`default_nettype none

module stm_mod_mixer #(
  parameter int DEPTH = 249
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     DIN_VALID,
  input  logic [7:0]               INTENSITY_IN,
  input  logic [7:0]               PHASE_IN,
  input  logic [7:0]               MOD_VALUE,
  input  logic                     MOD_EN,
  output logic [7:0]               INTENSITY_OUT,
  output logic [7:0]               PHASE_OUT,
  output logic                     DOUT_VALID,
  output logic [$clog2(DEPTH)-1:0] DOUT_IDX,
  output logic                     FRAME_DONE,
  output logic                     FRAME_ERR
);

  localparam int                 c_IW   = $clog2(DEPTH);
  localparam logic [c_IW-1:0]    c_LAST = c_IW'(DEPTH - 1);

  logic [c_IW-1:0] r_idx;
  logic [7:0]      r_m_lat;
  logic            r_en_lat;
  logic            r_err;

  logic            w_start;
  logic            w_last;
  logic [7:0]      w_m_eff;
  logic            w_en_eff;

  assign w_start  = DIN_VALID && (r_idx == '0);
  assign w_last   = (r_idx == c_LAST);
  // The first beat of a frame must see the live sample, not last frame's latch.
  assign w_m_eff  = w_start ? MOD_VALUE : r_m_lat;
  assign w_en_eff = w_start ? MOD_EN    : r_en_lat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_idx    <= '0;
      r_m_lat  <= '0;
      r_en_lat <= 1'b0;
      r_err    <= 1'b0;
    end else if (DIN_VALID) begin
      if (w_start) begin
        r_m_lat  <= MOD_VALUE;
        r_en_lat <= MOD_EN;
      end
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end else if (r_idx != '0) begin
      r_idx <= '0;
      r_err <= 1'b1;
    end
  end

  logic            r_s1_v, r_s1_en, r_s1_last;
  logic [7:0]      r_s1_i, r_s1_ph, r_s1_m;
  logic [c_IW-1:0] r_s1_idx;

  logic            r_s2_v, r_s2_en, r_s2_last;
  logic [7:0]      r_s2_i, r_s2_ph;
  logic [15:0]     r_s2_p;
  logic [c_IW-1:0] r_s2_idx;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_v    <= 1'b0;
      r_s1_en   <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_i    <= '0;
      r_s1_ph   <= '0;
      r_s1_m    <= '0;
      r_s1_idx  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_en   <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_i    <= '0;
      r_s2_ph   <= '0;
      r_s2_p    <= '0;
      r_s2_idx  <= '0;
    end else begin
      r_s1_v    <= DIN_VALID;
      r_s1_en   <= w_en_eff;
      r_s1_last <= w_last;
      r_s1_i    <= INTENSITY_IN;
      r_s1_ph   <= PHASE_IN;
      r_s1_m    <= w_m_eff;
      r_s1_idx  <= r_idx;
      r_s2_v    <= r_s1_v;
      r_s2_en   <= r_s1_en;
      r_s2_last <= r_s1_last;
      r_s2_i    <= r_s1_i;
      r_s2_ph   <= r_s1_ph;
      r_s2_p    <= 16'(r_s1_i) * 16'(r_s1_m);
      r_s2_idx  <= r_s1_idx;
    end
  end

  // round(p/255) via (q + q/256)/256 with q = p + 128; max sum stays below 2^16.
  logic [15:0] w_q;
  logic [7:0]  w_r;
  logic [7:0]  w_scaled;

  assign w_q      = r_s2_p + 16'd128;
  assign w_r      = 8'((w_q + {8'd0, w_q[15:8]}) >> 8);
  assign w_scaled = r_s2_en ? w_r : r_s2_i;

  always_ff @(posedge CLK) begin
    if (RST) begin
      INTENSITY_OUT <= '0;
      PHASE_OUT     <= '0;
      DOUT_VALID    <= 1'b0;
      DOUT_IDX      <= '0;
      FRAME_DONE    <= 1'b0;
    end else begin
      DOUT_VALID <= r_s2_v;
      FRAME_DONE <= r_s2_v && r_s2_last;
      if (r_s2_v) begin
        INTENSITY_OUT <= w_scaled;
        PHASE_OUT     <= r_s2_ph;
        DOUT_IDX      <= r_s2_idx;
      end
    end
  end

  assign FRAME_ERR = r_err;

endmodule

`default_nettype wire

// File: tb/tb_stm_mod_mixer.sv
// ============================================================================
// tb_stm_mod_mixer: randomized and directed checks against a behavioural model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stm_mod_mixer;
  localparam int DEPTH = 249;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       DIN_VALID = 1'b0;
  logic [7:0] INTENSITY_IN = '0, PHASE_IN = '0, MOD_VALUE = '0;
  logic       MOD_EN = 1'b0;
  logic [7:0] INTENSITY_OUT, PHASE_OUT;
  logic       DOUT_VALID, FRAME_DONE, FRAME_ERR;
  logic [7:0] DOUT_IDX;

  stm_mod_mixer #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DIN_VALID(DIN_VALID),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
    .MOD_VALUE(MOD_VALUE), .MOD_EN(MOD_EN),
    .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT),
    .DOUT_VALID(DOUT_VALID), .DOUT_IDX(DOUT_IDX),
    .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0, cyc = 0, done_cnt = 0;
  logic started = 1'b0;

  // Model state: frame position, latched modulation, scheduled outputs by edge.
  int         mid = 0, mlat = 0;
  logic       men = 1'b0, merr = 1'b0;
  logic       sv[8];
  logic [7:0] si[8], sp[8];
  int         sidx[8];
  logic       sd[8];
  logic       ev = 1'b0, ed = 1'b0;
  logic [7:0] ei = '0, ep = '0;
  int         eidx = 0;
  logic       lv[8];
  logic [7:0] lval[8];

  initial begin
    for (int k = 0; k < 8; k++) begin
      sv[k] = 1'b0;
      lv[k] = 1'b0;
    end
  end

  function automatic logic [7:0] ref_scale(input int i, input int m);
    return 8'((2 * i * m + 255) / 510);
  endfunction

  always @(posedge CLK) begin
    int s;
    cyc = cyc + 1;
    if (RST) begin
      started = 1'b1;
      mid = 0; mlat = 0; men = 1'b0; merr = 1'b0;
      ev = 1'b0; ed = 1'b0; ei = '0; ep = '0; eidx = 0;
      for (int k = 0; k < 8; k++) sv[k] = 1'b0;
    end else begin
      s = cyc % 8;
      if (sv[s]) begin
        ev = 1'b1; ei = si[s]; ep = sp[s]; eidx = sidx[s]; ed = sd[s];
        sv[s] = 1'b0;
      end else begin
        ev = 1'b0; ed = 1'b0;
      end
      if (DIN_VALID) begin
        if (mid == 0) begin
          mlat = int'(MOD_VALUE);
          men  = MOD_EN;
        end
        s = (cyc + 2) % 8;
        sv[s]   = 1'b1;
        si[s]   = men ? ref_scale(int'(INTENSITY_IN), mlat) : INTENSITY_IN;
        sp[s]   = PHASE_IN;
        sidx[s] = mid;
        sd[s]   = (mid == DEPTH - 1);
        mid = (mid + 1) % DEPTH;
      end else if (mid != 0) begin
        merr = 1'b1;
        mid  = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      tests++;
      if ({DOUT_VALID, FRAME_DONE, FRAME_ERR, INTENSITY_OUT, PHASE_OUT, DOUT_IDX} !==
          {ev, ed, merr, ei, ep, 8'(eidx)}) begin
        fails++;
        $display("FAIL model cyc=%0d act v=%b d=%b e=%b i=%0d p=%0d x=%0d req v=%b d=%b e=%b i=%0d p=%0d x=%0d",
                 cyc, DOUT_VALID, FRAME_DONE, FRAME_ERR, INTENSITY_OUT, PHASE_OUT, DOUT_IDX,
                 ev, ed, merr, ei, ep, eidx);
      end
      if (FRAME_DONE === 1'b1) done_cnt++;
      if (lv[cyc % 8]) begin
        tests++;
        if (DOUT_VALID !== 1'b1 || INTENSITY_OUT !== lval[cyc % 8]) begin
          fails++;
          $display("FAIL literal cyc=%0d act v=%b i=%0d req v=1 i=%0d",
                   cyc, DOUT_VALID, INTENSITY_OUT, lval[cyc % 8]);
        end
        lv[cyc % 8] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  task automatic beat(input logic [7:0] i, input logic [7:0] p, input logic [7:0] m, input logic en);
    DIN_VALID = 1'b1; INTENSITY_IN = i; PHASE_IN = p; MOD_VALUE = m; MOD_EN = en;
    tick();
  endtask

  task automatic idle(input int n);
    DIN_VALID = 1'b0;
    repeat (n) tick();
  endtask

  // First beat carries a pinned intensity with a hand-computed expected output.
  task automatic frame(input logic [7:0] m, input logic en, input logic [7:0] m2,
                       input logic en2, input int chg, input int n,
                       input logic [7:0] i0, input logic [7:0] e0);
    for (int b = 0; b < n; b++) begin
      logic [7:0] iv;
      iv = (b == 0) ? i0 : 8'($urandom);
      if (b == 0) begin
        lv[(cyc + 3) % 8]   = 1'b1;
        lval[(cyc + 3) % 8] = e0;
      end
      beat(iv, 8'($urandom), (b < chg) ? m : m2, (b < chg) ? en : en2);
    end
  endtask

  initial begin
    int d0;
    RST = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(DOUT_VALID), 0);
    chk("rst_int", 32'(INTENSITY_OUT), 0);
    chk("rst_err", 32'(FRAME_ERR), 0);
    RST = 1'b0;

    for (int b = 0; b < DEPTH; b++) beat(8'(b), 8'(b), 8'd255, 1'b1);
    idle(5);
    chk("done_pass", done_cnt, 1);

    frame(8'd128, 1'b1, 8'd128, 1'b1, DEPTH, DEPTH, 8'd255, 8'd128);
    frame(8'd128, 1'b1, 8'd128, 1'b1, DEPTH, DEPTH, 8'd1,   8'd1);
    frame(8'd128, 1'b1, 8'd128, 1'b1, DEPTH, DEPTH, 8'd2,   8'd1);
    frame(8'd0,   1'b1, 8'd0,   1'b1, DEPTH, DEPTH, 8'd200, 8'd0);
    frame(8'd1,   1'b1, 8'd1,   1'b1, DEPTH, DEPTH, 8'd255, 8'd1);
    frame(8'd255, 1'b1, 8'd255, 1'b1, DEPTH, DEPTH, 8'd255, 8'd255);
    frame(8'd200, 1'b1, 8'd50,  1'b1, 100,   DEPTH, 8'd255, 8'd200);
    frame(8'd50,  1'b1, 8'd50,  1'b1, DEPTH, DEPTH, 8'd255, 8'd50);
    frame(8'd0,   1'b0, 8'd0,   1'b1, 100,   DEPTH, 8'd7,   8'd7);
    idle(5);
    chk("done_frames", done_cnt, 10);

    d0 = done_cnt;
    frame(8'd90, 1'b1, 8'd90, 1'b1, DEPTH, 10, 8'd255, 8'd90);
    idle(6);
    chk("trunc_err", 32'(FRAME_ERR), 1);
    chk("trunc_nodone", done_cnt, d0);
    frame(8'd60, 1'b1, 8'd60, 1'b1, DEPTH, DEPTH, 8'd100, 8'd24);
    idle(5);
    chk("after_trunc_done", done_cnt, d0 + 1);
    chk("err_sticky", 32'(FRAME_ERR), 1);

    frame(8'd30, 1'b1, 8'd30, 1'b1, DEPTH, 50, 8'd255, 8'd30);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_valid", 32'(DOUT_VALID), 0);
    chk("midrst_int", 32'(INTENSITY_OUT), 0);
    chk("midrst_phase", 32'(PHASE_OUT), 0);
    chk("midrst_idx", 32'(DOUT_IDX), 0);
    chk("midrst_err", 32'(FRAME_ERR), 0);
    frame(8'd100, 1'b1, 8'd20, 1'b1, 1, DEPTH, 8'd255, 8'd100);

    for (int f = 0; f < 42; f++) begin
      logic [7:0] m;
      logic       en;
      int         n;
      m  = 8'($urandom);
      en = ($urandom_range(0, 3) != 0);
      n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, DEPTH - 1)) : DEPTH;
      for (int b = 0; b < n; b++)
        beat(8'($urandom), 8'($urandom), (b == 0) ? m : 8'($urandom),
             (b == 0) ? en : 1'($urandom));
      if (n < DEPTH || $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)));
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
